eh2_lsu_bus_clken_gen: RTL and testbench

Generates the LSU bus clock enable, `lsu_bus_clk_en`, for a bus running at an integer fraction of the core clock. Also produces the bus-aligned, per-thread force-halt indication, `dec_tlu_force_halt_bus`, together with a halt-drained status. It sits between the TLU and the LSU clock-gating and bus logic, on the producing side of those two signals. Ratio changes and halt transitions are applied only on bus-cycle boundaries, so the bus domain never sees a truncated cycle.

---
 rtl/eh2_pkg.sv | 15 +
 rtl/eh2_lsu_bus_halt_sync.sv | 53 +++++
 rtl/eh2_lsu_bus_clken_gen.sv | 79 +++++++
 tb/tb_eh2_lsu_bus_clken_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared EH2 types: the per-thread bus-halt synchroniser state and default
// sizing for the LSU bus clock-enable generator.
package eh2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2,
    DONE = 2'd3
  } eh2_bus_halt_state_t;

  localparam int unsigned BUS_NUM_THREADS_DEF = 2;
  localparam int unsigned BUS_RATIO_W_DEF     = 3;

endpackage

// File: rtl/eh2_lsu_bus_halt_sync.sv
// One thread's force-halt synchroniser: moves between states only on bus
// boundaries (en_next_i) so the bus domain sees whole-period halt levels.
module eh2_lsu_bus_halt_sync
  import eh2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       en_next_i,
  input  logic       force_halt_i,
  input  logic       bus_idle_i,
  output logic       force_halt_bus_o,
  output logic       halt_done_o,
  output logic [1:0] state_dbg_o
);

  eh2_bus_halt_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // PEND remembers a halt request shorter than a bus period, so it is never
  // released before it has been presented as HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (force_halt_i) state_d = en_next_i ? HALT : PEND;
      end
      PEND: begin
        if (en_next_i) state_d = HALT;
      end
      HALT: begin
        if (en_next_i) begin
          if (!force_halt_i)   state_d = IDLE;
          else if (bus_idle_i) state_d = DONE;
        end
      end
      DONE: begin
        if (en_next_i && !force_halt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    force_halt_bus_o = (state_q == HALT) || (state_q == DONE);
    halt_done_o      = (state_q == DONE);
    state_dbg_o      = state_q;
  end

endmodule

// File: rtl/eh2_lsu_bus_clken_gen.sv
// LSU bus clock-enable generator for a bus at core/(ratio+1), plus the
// bus-aligned per-thread force-halt and halt-drained indications.
module eh2_lsu_bus_clken_gen
  import eh2_pkg::*;
#(
  parameter int NUM_THREADS = BUS_NUM_THREADS_DEF,
  parameter int RATIO_W     = BUS_RATIO_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     scan_mode,
  input  logic [RATIO_W-1:0]       bus_ratio,
  input  logic                     ratio_ld,
  input  logic [NUM_THREADS-1:0]   dec_tlu_force_halt,
  input  logic [NUM_THREADS-1:0]   lsu_bus_idle_any,
  output logic                     lsu_bus_clk_en,
  output logic                     ratio_pend,
  output logic [NUM_THREADS-1:0]   dec_tlu_force_halt_bus,
  output logic [NUM_THREADS-1:0]   lsu_bus_halt_done,
  output logic [2*NUM_THREADS-1:0] halt_state_dbg
);

  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [RATIO_W-1:0] ratio_nxt_q, ratio_nxt_d;
  logic               pend_q, pend_d;
  logic               clk_en_q;
  logic               en_next;
  logic               apply;
  logic               unused_scan_mode;

  assign unused_scan_mode = scan_mode;

  assign en_next = (cnt_q == ratio_q);
  assign apply   = en_next & pend_q;

  // A new ratio only takes effect at a boundary, so the running bus period
  // always completes at its old length. A load coinciding with an apply
  // stays pending for the following boundary.
  always_comb begin
    cnt_d       = en_next ? '0 : cnt_q + RATIO_W'(1);
    ratio_d     = apply ? ratio_nxt_q : ratio_q;
    ratio_nxt_d = ratio_ld ? bus_ratio : ratio_nxt_q;
    pend_d      = ratio_ld | (pend_q & ~en_next);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q       <= '0;
      ratio_q     <= '0;
      ratio_nxt_q <= '0;
      pend_q      <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      ratio_nxt_q <= ratio_nxt_d;
      pend_q      <= pend_d;
      clk_en_q    <= en_next;
    end
  end

  assign lsu_bus_clk_en = clk_en_q;
  assign ratio_pend     = pend_q;

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
    eh2_lsu_bus_halt_sync u_sync (
      .clk              (clk),
      .rst_l            (rst_l),
      .en_next_i        (en_next),
      .force_halt_i     (dec_tlu_force_halt[i]),
      .bus_idle_i       (lsu_bus_idle_any[i]),
      .force_halt_bus_o (dec_tlu_force_halt_bus[i]),
      .halt_done_o      (lsu_bus_halt_done[i]),
      .state_dbg_o      (halt_state_dbg[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_eh2_lsu_bus_clken_gen.sv
// Bench for eh2_lsu_bus_clken_gen: directed scenarios with literal checks,
// then random traffic, all compared every cycle against a boundary-time model.
module tb_eh2_lsu_bus_clken_gen;

  localparam int NT = 2;
  localparam int RW = 3;

  logic          clk;
  logic          rst_l;
  logic          scan_mode;
  logic [RW-1:0] bus_ratio;
  logic          ratio_ld;
  logic [NT-1:0] fh;
  logic [NT-1:0] idle;
  logic          lsu_bus_clk_en;
  logic          ratio_pend;
  logic [NT-1:0] hb;
  logic [NT-1:0] hd;
  logic [2*NT-1:0] dbg;

  int n_chk  = 0;
  int n_fail = 0;

  eh2_lsu_bus_clken_gen #(.NUM_THREADS(NT), .RATIO_W(RW)) dut (
    .clk                    (clk),
    .rst_l                  (rst_l),
    .scan_mode              (scan_mode),
    .bus_ratio              (bus_ratio),
    .ratio_ld               (ratio_ld),
    .dec_tlu_force_halt     (fh),
    .lsu_bus_idle_any       (idle),
    .lsu_bus_clk_en         (lsu_bus_clk_en),
    .ratio_pend             (ratio_pend),
    .dec_tlu_force_halt_bus (hb),
    .lsu_bus_halt_done      (hd),
    .halt_state_dbg         (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Boundaries are tracked as absolute edge numbers since reset release.
  int         e;
  int         next_b;
  logic [2:0] m_ratio, m_nxt;
  bit         m_pend, m_en;
  bit [NT-1:0] m_halt, m_done, m_req;

  task automatic model_reset();
    e = 0; next_b = 1; m_ratio = 0; m_nxt = 0;
    m_pend = 0; m_en = 0; m_halt = '0; m_done = '0; m_req = '0;
  endtask

  task automatic model_step();
    bit bnd;
    e++;
    bnd = (e == next_b);
    if (bnd) begin
      if (m_pend) begin
        m_ratio = m_nxt;
        m_pend  = 0;
      end
      next_b = e + int'(m_ratio) + 1;
    end
    if (ratio_ld) begin
      m_nxt  = bus_ratio;
      m_pend = 1;
    end
    m_en = bnd;
    for (int t = 0; t < NT; t++) begin
      if (bnd) begin
        if (!m_halt[t]) begin
          m_halt[t] = fh[t] | m_req[t];
          m_done[t] = 0;
        end else if (!fh[t]) begin
          m_halt[t] = 0;
          m_done[t] = 0;
        end else if (idle[t]) begin
          m_done[t] = 1;
        end
        m_req[t] = 0;
      end else if (!m_halt[t] && fh[t]) begin
        m_req[t] = 1;
      end
    end
  endtask

  function automatic logic [2*NT-1:0] exp_dbg();
    logic [2*NT-1:0] v;
    v = '0;
    for (int t = 0; t < NT; t++)
      v[2*t +: 2] = m_done[t] ? 2'd3 : m_halt[t] ? 2'd2 : m_req[t] ? 2'd1 : 2'd0;
    return v;
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    if (!rst_l) model_reset();
    else        model_step();
    #1;
    chk("m_clk_en", 32'(lsu_bus_clk_en), 32'(m_en));
    chk("m_pend",   32'(ratio_pend),     32'(m_pend));
    chk("m_halt_bus", 32'(hb),           32'(m_halt));
    chk("m_halt_done", 32'(hd),          32'(m_done));
    chk("m_state",  32'(dbg),            32'(exp_dbg()));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [RW-1:0] r);
    bus_ratio = r;
    ratio_ld  = 1'b1;
    step();
    ratio_ld  = 1'b0;
  endtask

  // Runs until a boundary edge that left nothing pending, bounded.
  task automatic wait_bnd(input string nm);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(lsu_bus_clk_en && !ratio_pend) && k < 40);
    chk(nm, 32'(lsu_bus_clk_en & ~ratio_pend), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_l = 1'b0; scan_mode = 1'b0; bus_ratio = '0; ratio_ld = 1'b0;
    fh = '0; idle = '1;
    step(); step();
    chk("rst_en", 32'(lsu_bus_clk_en), 0);
    chk("rst_pend", 32'(ratio_pend), 0);
    chk("rst_hb", 32'(hb), 0);
    chk("rst_hd", 32'(hd), 0);
    rst_l = 1'b1;

    // ratio 0 after reset, then load 2
    step(); chk("r0_edge1", 32'(lsu_bus_clk_en), 1);
    step(); chk("r0_edge2", 32'(lsu_bus_clk_en), 1);
    load(3'd2);
    chk("ld2_pend", 32'(ratio_pend), 1);
    step();
    chk("ld2_apply_pend", 32'(ratio_pend), 0);
    chk("ld2_apply_en", 32'(lsu_bus_clk_en), 1);
    for (int i = 0; i < 2; i++) begin
      step(); chk("r2_p0", 32'(lsu_bus_clk_en), 0);
      step(); chk("r2_p1", 32'(lsu_bus_clk_en), 0);
      step(); chk("r2_p2", 32'(lsu_bus_clk_en), 1);
    end

    // ratio 3, then load 1 with cnt=1
    load(3'd3);
    wait_bnd("to_r3");
    step();
    load(3'd1);
    chk("r3to1_a", 32'(lsu_bus_clk_en), 0);
    chk("r3to1_pend", 32'(ratio_pend), 1);
    step(); chk("r3to1_b", 32'(lsu_bus_clk_en), 0);
    step(); chk("r3to1_c", 32'(lsu_bus_clk_en), 1);
    chk("r3to1_applied", 32'(ratio_pend), 0);
    step(); chk("r1_a", 32'(lsu_bus_clk_en), 0);
    step(); chk("r1_b", 32'(lsu_bus_clk_en), 1);

    // loads 5 then 7 before the boundary: only 7 is used
    step();
    bus_ratio = 3'd5; ratio_ld = 1'b1;
    step(); chk("ld5_en", 32'(lsu_bus_clk_en), 1);
    chk("ld5_pend", 32'(ratio_pend), 1);
    bus_ratio = 3'd7;
    step(); ratio_ld = 1'b0;
    chk("ld7_pend", 32'(ratio_pend), 1);
    step(); chk("ld7_apply", 32'(lsu_bus_clk_en), 1);
    for (int i = 0; i < 7; i++) begin
      step(); chk("r7_low", 32'(lsu_bus_clk_en), 0);
    end
    step(); chk("r7_high", 32'(lsu_bus_clk_en), 1);

    // ratio 3, one-cycle halt pulse on thread 0 at cnt=0
    load(3'd3);
    wait_bnd("to_r3b");
    fh = 2'b01;
    step(); fh = 2'b00;
    chk("pulse_pend_hb", 32'(hb), 0);
    chk("pulse_pend_st", 32'(dbg[1:0]), 1);
    step(); chk("pulse_w1", 32'(hb), 0);
    step(); chk("pulse_w2", 32'(hb), 0);
    step(); chk("pulse_halt", 32'(hb), 1);
    chk("pulse_halt_en", 32'(lsu_bus_clk_en), 1);
    for (int i = 0; i < 3; i++) begin
      step(); chk("pulse_hold", 32'(hb), 1);
    end
    step(); chk("pulse_rel", 32'(hb), 0);

    // ratio 1, held halt, bus busy then drained
    load(3'd1);
    wait_bnd("to_r1");
    fh = 2'b01; idle = 2'b00;
    step(); chk("busy_pend", 32'(hb), 0);
    step(); chk("busy_halt", 32'(hb), 1);
    for (int i = 0; i < 6; i++) begin
      step(); chk("busy_nodone", 32'(hd), 0);
    end
    idle = 2'b11;
    step(); chk("drain_mid", 32'(hd), 0);
    step(); chk("drain_done", 32'(hd), 1);
    fh = 2'b00;
    step(); chk("drop_mid", 32'(hd), 1);
    step(); chk("drop_hb", 32'(hb), 0);
    chk("drop_hd", 32'(hd), 0);

    // thread 0 releases while thread 1 halts on the same boundary
    fh = 2'b01;
    step(); step();
    chk("t0_halt", 32'(hb), 32'h1);
    step();
    fh = 2'b10;
    step(); chk("swap_hb", 32'(hb), 32'h2);
    fh = 2'b00;
    step(); step(); chk("swap_rel", 32'(hb), 0);

    // reset while DONE at ratio 5
    load(3'd5);
    wait_bnd("to_r5");
    fh = 2'b01;
    begin
      int k;
      k = 0;
      while (!hd[0] && k < 30) begin
        step();
        k++;
      end
    end
    chk("r5_done", 32'(hd), 32'h1);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_en", 32'(lsu_bus_clk_en), 0);
    chk("arst_hb", 32'(hb), 0);
    chk("arst_hd", 32'(hd), 0);
    chk("arst_pend", 32'(ratio_pend), 0);
    fh = 2'b00;
    step();
    rst_l = 1'b1;
    step(); chk("post_rst_edge1", 32'(lsu_bus_clk_en), 1);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      ratio_ld  = ($urandom_range(0, 9) == 0);
      bus_ratio = RW'($urandom_range(0, 7));
      for (int t = 0; t < NT; t++) begin
        if ($urandom_range(0, 7) == 0) fh[t] = ~fh[t];
        idle[t] = ($urandom_range(0, 3) != 0);
      end
      rst_l = !(c == 1500);
      step();
    end
    rst_l = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
